axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- Single-beat AXI slave that terminates the load/store unit's external AXI master port in a local byte-writable SRAM.
- Sits directly downstream of the LS AXI master, used for simulation and small on-chip data memory.
- Accepts AR, AW and W channels and returns R and B responses.
- One transaction in flight at a time, in-order, no IDs.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of word 0; must be aligned to the memory size.
- MEM_WORDS, 1024, number of 32-bit words; power of two, at least 2.
- WRITE_PRIORITY, 1, when 1 a pending write wins over a simultaneous read in IDLE; when 0 the read wins.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- araddr  in  32  read address
- arlen  in  8  burst length; only 0 is supported
- arvalid  in  1  read address valid
- arready  out  1  read address accepted
- rdata  out  32  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  master ready for read data
- awaddr  in  32  write address
- awlen  in  8  burst length; only 0 is supported
- awvalid  in  1  write address valid
- awready  out  1  write address accepted
- wdata  in  32  write data
- wstrb  in  4  byte enables
- wvalid  in  1  write data valid
- wready  out  1  write data accepted
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  master ready for write response

Behaviour:
- Clock clk, reset rst (synchronous, active-high).
- Reset state: IDLE; rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0. SRAM contents are not reset.
- State machine: IDLE, W_NEED_W (AW held, waiting for W), W_NEED_AW (W held, waiting for AW), B_RESP, R_RESP.
- Ready signals (all combinational from state and valids):
  - arready = IDLE & (WRITE_PRIORITY ? ~(awvalid|wvalid) : 1).
  - awready = IDLE | W_NEED_AW.
  - wready = IDLE | W_NEED_W. When WRITE_PRIORITY=0, awready and wready are also gated by ~arvalid in IDLE.
- Read path:
  - AR handshake in cycle T: the SRAM is read using araddr in cycle T.
  - Cycle T+1: rvalid=1 with rdata and rresp. State R_RESP.
  - rvalid, rdata and rresp are held stable until rready. Return to IDLE on the cycle rvalid&rready. No new AR is accepted in that cycle.
  - Minimum read turnaround: 2 cycles per load.
- Write path:
  - AW and W may arrive in either order or in the same cycle. The first-arriving channel is captured into a register.
  - The SRAM write commits in the cycle the second channel handshakes; for a same-cycle arrival, it commits in that cycle.
  - Next cycle: bvalid=1 with bresp, state B_RESP, held until bready. Then IDLE.
  - Only lanes with wstrb[i]=1 are written. wstrb=0 is legal: no update, OKAY response.
- Address decode:
  - Word index = addr[2 +: log2(MEM_WORDS)]. addr[1:0] is ignored; the byte strobes govern.
  - In range iff (addr - BASE_ADDR) < MEM_WORDS*4.
  - Out of range: response DECERR (2'b11), no SRAM write, rdata=0.
- Length check: arlen or awlen != 0 -> SLVERR (2'b10), no SRAM write, rdata=0. Exactly one beat is returned regardless. DECERR takes precedence over SLVERR.
- Successful transaction: OKAY (2'b00).
- Read-after-write: a read accepted after the B handshake returns the new data; there is no bypass path needed.
- Reset mid-transaction: any captured AW/W is discarded, the pending write is not committed, and rvalid/bvalid drop in the cycle after rst.
- Master holding rready=0 or bready=0 indefinitely: the slave stalls; no other channel is accepted.

Decomposition:
- Shared package (taiga_types):
  - axi_resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - axi_slave_state_t for the five states.
- Sub-module byte_en_sram:
  - Parameter DEPTH.
  - Ports: clk, addr, en, be[3:0], wdata, rdata.
  - Synchronous 1-cycle read, per-byte write enable.
  - Read-during-write to the same address returns old data.

Test Plan:
- Write/read: AW+W same cycle, addr 0x8000_0010, wdata 0xDEADBEEF, wstrb 4'hF -> bvalid next cycle with bresp=0. Then AR to 0x8000_0010 -> rvalid one cycle after arready, rdata=0xDEADBEEF, rresp=0.
- Byte strobes: word preloaded with 0x11223344, write 0xAABBCCDD with wstrb 4'b0101 -> read returns 0x11BB33DD.
- Channel ordering:
  - W 3 cycles before AW -> wready=1 in the W cycle, awready=1 when AW arrives, write commits once, single bvalid pulse.
  - AW before W -> same result.
- Errors:
  - Read at 0x8000_1000 (MEM_WORDS=1024) -> rresp=2'b11, rdata=0.
  - Write with awlen=3 -> bresp=2'b10, memory unchanged.
- Backpressure: rready held 0 for 5 cycles -> rvalid and rdata stable for all 5 cycles, arready=0 throughout. One cycle after the handshake, arready=1.
- Collision and reset:
  - WRITE_PRIORITY=1, arvalid and awvalid+wvalid raised together -> write serviced first, read after B handshake.
  - rst asserted with AW held in W_NEED_W -> the later W is not committed, and a subsequent read returns the old value.

Source files
------------

// File: rtl/taiga_types.sv
// Types shared by the AXI slave and its helpers: response codes, slave FSM
// states and the address/length decode used on both read and write paths.
package taiga_types;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_t;

   typedef enum logic [2:0] {
      IDLE,
      W_NEED_W,
      W_NEED_AW,
      B_RESP,
      R_RESP
   } axi_slave_state_t;

   // Out-of-range addresses win over unsupported burst lengths.
   function automatic axi_resp_t decode_resp(input logic [31:0] addr,
                                             input logic [7:0]  len,
                                             input logic [31:0] base,
                                             input logic [31:0] bytes);
      logic [31:0] offset;
      offset = addr - base;
      if (offset >= bytes) return DECERR;
      if (len != 8'd0) return SLVERR;
      return OKAY;
   endfunction

endpackage

// File: rtl/byte_en_sram.sv
// Single-port 32-bit SRAM with per-byte write enables and a registered read.
// A read that coincides with a write to the same word returns the old data.
module byte_en_sram #(
   parameter int DEPTH = 1024,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic          en,
   input  logic [3:0]    be,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         rdata_q <= mem[addr];
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// Single-beat AXI slave backed by a byte-writable SRAM. One transaction at a
// time; AW and W may arrive in any order and the first one is parked in a register.
module axi_sram_slave
   import taiga_types::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
   parameter int          MEM_WORDS      = 1024,
   parameter bit          WRITE_PRIORITY = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int          IDX_W     = $clog2(MEM_WORDS);
   localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

   // Handshakes: a transfer happens on a rising clk edge where valid & ready.
   // Readies are combinational from state and the incoming valids only.
   axi_slave_state_t state_q, state_d;
   logic [31:0]      aw_addr_q, aw_addr_d;
   logic [7:0]       aw_len_q, aw_len_d;
   logic [31:0]      w_data_q, w_data_d;
   logic [3:0]       w_strb_q, w_strb_d;
   axi_resp_t        rresp_q, rresp_d;
   axi_resp_t        bresp_q, bresp_d;
   logic             rd_ok_q, rd_ok_d;

   logic             idle, accept_wr;
   logic             ar_hs, aw_hs, w_hs, wr_fire;
   logic [31:0]      wr_addr, wr_data;
   logic [7:0]       wr_len;
   logic [3:0]       wr_strb;
   axi_resp_t        ar_resp, wr_resp;

   logic             sram_en;
   logic [3:0]       sram_be;
   logic [IDX_W-1:0] sram_addr;
   logic [31:0]      sram_rdata;

   assign idle      = (state_q == IDLE);
   assign accept_wr = idle & (WRITE_PRIORITY | ~arvalid);
   assign arready   = idle & (~WRITE_PRIORITY | ~(awvalid | wvalid));
   assign awready   = accept_wr | (state_q == W_NEED_AW);
   assign wready    = accept_wr | (state_q == W_NEED_W);

   assign ar_hs = arvalid & arready;
   assign aw_hs = awvalid & awready;
   assign w_hs  = wvalid & wready;

   // The channel that arrived first comes from its holding register.
   assign wr_addr = (state_q == W_NEED_W)  ? aw_addr_q : awaddr;
   assign wr_len  = (state_q == W_NEED_W)  ? aw_len_q  : awlen;
   assign wr_data = (state_q == W_NEED_AW) ? w_data_q  : wdata;
   assign wr_strb = (state_q == W_NEED_AW) ? w_strb_q  : wstrb;

   assign wr_fire = (idle & aw_hs & w_hs)
                  | ((state_q == W_NEED_W) & w_hs)
                  | ((state_q == W_NEED_AW) & aw_hs);

   assign ar_resp = decode_resp(araddr, arlen, BASE_ADDR, MEM_BYTES);
   assign wr_resp = decode_resp(wr_addr, wr_len, BASE_ADDR, MEM_BYTES);

   // Reads and writes never fire together, so one shared port suffices.
   assign sram_en   = ~rst & ((ar_hs & (ar_resp == OKAY)) | (wr_fire & (wr_resp == OKAY)));
   assign sram_be   = wr_fire ? wr_strb : 4'b0000;
   assign sram_addr = wr_fire ? wr_addr[2 +: IDX_W] : araddr[2 +: IDX_W];

   byte_en_sram #(.DEPTH(MEM_WORDS)) u_sram (
      .clk   (clk),
      .addr  (sram_addr),
      .en    (sram_en),
      .be    (sram_be),
      .wdata (wr_data),
      .rdata (sram_rdata)
   );

   always_comb begin
      state_d   = state_q;
      aw_addr_d = aw_addr_q;
      aw_len_d  = aw_len_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      rresp_d   = rresp_q;
      bresp_d   = bresp_q;
      rd_ok_d   = rd_ok_q;
      case (state_q)
         IDLE: begin
            if (ar_hs) begin
               state_d = R_RESP;
               rresp_d = ar_resp;
               rd_ok_d = (ar_resp == OKAY);
            end else if (wr_fire) begin
               state_d = B_RESP;
               bresp_d = wr_resp;
            end else if (aw_hs) begin
               state_d   = W_NEED_W;
               aw_addr_d = awaddr;
               aw_len_d  = awlen;
            end else if (w_hs) begin
               state_d  = W_NEED_AW;
               w_data_d = wdata;
               w_strb_d = wstrb;
            end
         end
         W_NEED_W, W_NEED_AW: begin
            if (wr_fire) begin
               state_d = B_RESP;
               bresp_d = wr_resp;
            end
         end
         B_RESP:  if (bready) state_d = IDLE;
         R_RESP:  if (rready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         aw_addr_q <= '0;
         aw_len_q  <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         rresp_q   <= OKAY;
         bresp_q   <= OKAY;
         rd_ok_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         aw_addr_q <= aw_addr_d;
         aw_len_q  <= aw_len_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         rresp_q   <= rresp_d;
         bresp_q   <= bresp_d;
         rd_ok_q   <= rd_ok_d;
      end
   end

   // The SRAM output is untouched while in R_RESP, so rdata holds by itself.
   assign rvalid = (state_q == R_RESP);
   assign bvalid = (state_q == B_RESP);
   assign rdata  = (rvalid && rd_ok_q) ? sram_rdata : 32'h0;
   assign rresp  = rresp_q;
   assign bresp  = bresp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: directed scenarios plus a random
// back-to-back mix checked against a byte-level memory model.
module tb_axi_sram_slave;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic        arvalid, arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid, rready;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic        awvalid, awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid, wready;
   logic [1:0]  bresp;
   logic        bvalid, bready;

   int          n_pass = 0;
   int          n_total = 0;
   logic [31:0] exp_q[$];
   logic [31:0] model [1024];

   always #5 clk = ~clk;

   axi_sram_slave #(
      .BASE_ADDR      (32'h8000_0000),
      .MEM_WORDS      (1024),
      .WRITE_PRIORITY (1'b1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .araddr  (araddr),
      .arlen   (arlen),
      .arvalid (arvalid),
      .arready (arready),
      .rdata   (rdata),
      .rresp   (rresp),
      .rvalid  (rvalid),
      .rready  (rready),
      .awaddr  (awaddr),
      .awlen   (awlen),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wvalid  (wvalid),
      .wready  (wready),
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int midx(input logic [31:0] a);
      return int'(a[11:2]);
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      for (int i = 0; i < 4; i++) begin
         if (s[i]) model[midx(a)][8*i +: 8] = d[8*i +: 8];
      end
   endtask

   // w_lead > 0: W leads AW by that many cycles; < 0: AW leads W.
   task automatic axi_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [31:0] data, input logic [3:0] strb, input int w_lead,
                            output int aw_cyc, output int w_cyc, output int b_lat,
                            output logic [1:0] resp, output int b_pulses);
      int  aw_start, w_start, c;
      bit  aw_done, w_done;
      aw_start = (w_lead > 0) ? w_lead : 0;
      w_start  = (w_lead < 0) ? -w_lead : 0;
      aw_cyc = -1; w_cyc = -1; b_lat = -1; resp = 2'bxx; b_pulses = 0;
      aw_done = 0; w_done = 0; c = 0;
      awaddr = addr; awlen = len; wdata = data; wstrb = strb; bready = 1'b1;
      while (!(aw_done && w_done) && c < 40) begin
         awvalid = !aw_done && (c >= aw_start);
         wvalid  = !w_done && (c >= w_start);
         @(negedge clk);
         if (awvalid && awready) begin aw_done = 1; aw_cyc = c; end
         if (wvalid && wready) begin w_done = 1; w_cyc = c; end
         if (bvalid) b_pulses++;
         tick();
         c++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (bvalid) begin
            b_pulses++;
            if (b_lat < 0) begin b_lat = k; resp = bresp; end
         end
         tick();
      end
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input int stall,
                           output int r_lat, output logic [31:0] data, output logic [1:0] resp,
                           output bit stable, output logic ar_after);
      int c;
      bit done;
      r_lat = -1; data = 'x; resp = 'x; stable = 1; ar_after = 1'bx;
      araddr = addr; arlen = len; arvalid = 1'b1; rready = (stall == 0); c = 0; done = 0;
      while (!done && c < 40) begin
         @(negedge clk);
         if (arready) done = 1;
         tick();
         c++;
      end
      arvalid = 1'b0;
      if (!done) begin rready = 1'b0; return; end
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (rvalid) begin r_lat = k; data = rdata; resp = rresp; break; end
         tick();
      end
      if (r_lat < 0) begin rready = 1'b0; return; end
      for (int s = 0; s < stall; s++) begin
         if (!(rvalid === 1'b1 && rdata === data && rresp === resp && arready === 1'b0)) stable = 0;
         tick();
         @(negedge clk);
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      @(negedge clk);
      ar_after = arready;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      arvalid = 0; awvalid = 0; wvalid = 0; rready = 0; bready = 0;
      araddr = '0; arlen = '0; awaddr = '0; awlen = '0; wdata = '0; wstrb = '0;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      n_total++;
      if ({rvalid, bvalid} !== 2'b00) $display("FAIL reset_valids: got %b want 00", {rvalid, bvalid});
      else n_pass++;
      n_total++;
      if ({rdata, rresp, bresp} !== 36'h0) $display("FAIL reset_data: got %h want 0", {rdata, rresp, bresp});
      else n_pass++;
      n_total++;
      if ({arready, awready, wready} !== 3'b111) $display("FAIL reset_readies: got %b want 111", {arready, awready, wready});
      else n_pass++;
      tick();
   endtask

   task automatic test_write_read();
      int aw_c, w_c, b_l, b_p, r_l;
      logic [1:0] resp;
      logic [31:0] d, e;
      bit st;
      logic ar_a;
      axi_write(BASE + 32'h10, 8'd0, 32'hDEAD_BEEF, 4'hF, 0, aw_c, w_c, b_l, resp, b_p);
      model_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
      n_total++;
      if (aw_c !== 0 || w_c !== 0) $display("FAIL wr_same_hs: got aw=%0d w=%0d want 0 0", aw_c, w_c);
      else n_pass++;
      n_total++;
      if (b_l !== 1 || b_p !== 1) $display("FAIL wr_same_b: got lat=%0d pulses=%0d want 1 1", b_l, b_p);
      else n_pass++;
      n_total++;
      if (resp !== 2'b00) $display("FAIL wr_same_bresp: got %b want 00", resp);
      else n_pass++;
      exp_q.push_back(32'hDEAD_BEEF);
      axi_read(BASE + 32'h10, 8'd0, 0, r_l, d, resp, st, ar_a);
      e = exp_q.pop_front();
      n_total++;
      if (r_l !== 1) $display("FAIL rd_latency: got %0d want 1", r_l);
      else n_pass++;
      n_total++;
      if (d !== e || resp !== 2'b00) $display("FAIL rd_data: got %h/%b want %h/00", d, resp, e);
      else n_pass++;
   endtask

   task automatic test_strobes();
      int aw_c, w_c, b_l, b_p, r_l;
      logic [1:0] resp;
      logic [31:0] d, e;
      bit st;
      logic ar_a;
      axi_write(BASE + 32'h20, 8'd0, 32'h1122_3344, 4'hF, 0, aw_c, w_c, b_l, resp, b_p);
      axi_write(BASE + 32'h20, 8'd0, 32'hAABB_CCDD, 4'b0101, 0, aw_c, w_c, b_l, resp, b_p);
      model_write(BASE + 32'h20, 32'h1122_3344, 4'hF);
      model_write(BASE + 32'h20, 32'hAABB_CCDD, 4'b0101);
      exp_q.push_back(32'h11BB_33DD);
      axi_read(BASE + 32'h20, 8'd0, 0, r_l, d, resp, st, ar_a);
      e = exp_q.pop_front();
      n_total++;
      if (d !== e) $display("FAIL strb_merge: got %h want %h", d, e);
      else n_pass++;
      axi_write(BASE + 32'h20, 8'd0, 32'h0000_0000, 4'b0000, 0, aw_c, w_c, b_l, resp, b_p);
      n_total++;
      if (resp !== 2'b00 || b_l !== 1) $display("FAIL strb_zero_resp: got %b lat=%0d want 00 lat=1", resp, b_l);
      else n_pass++;
      exp_q.push_back(model[midx(BASE + 32'h20)]);
      axi_read(BASE + 32'h20, 8'd0, 0, r_l, d, resp, st, ar_a);
      e = exp_q.pop_front();
      n_total++;
      if (d !== e) $display("FAIL strb_zero_data: got %h want %h", d, e);
      else n_pass++;
   endtask

   task automatic test_channel_order();
      int aw_c, w_c, b_l, b_p, r_l;
      logic [1:0] resp;
      logic [31:0] d, e;
      bit st;
      logic ar_a;
      axi_write(BASE + 32'h30, 8'd0, 32'hCAFE_F00D, 4'hF, 3, aw_c, w_c, b_l, resp, b_p);
      model_write(BASE + 32'h30, 32'hCAFE_F00D, 4'hF);
      n_total++;
      if (w_c !== 0 || aw_c !== 3) $display("FAIL wfirst_hs: got w=%0d aw=%0d want 0 3", w_c, aw_c);
      else n_pass++;
      n_total++;
      if (b_l !== 1 || b_p !== 1 || resp !== 2'b00) $display("FAIL wfirst_b: got lat=%0d pulses=%0d resp=%b want 1 1 00", b_l, b_p, resp);
      else n_pass++;
      axi_write(BASE + 32'h34, 8'd0, 32'h0BAD_C0DE, 4'hF, -2, aw_c, w_c, b_l, resp, b_p);
      model_write(BASE + 32'h34, 32'h0BAD_C0DE, 4'hF);
      n_total++;
      if (aw_c !== 0 || w_c !== 2) $display("FAIL awfirst_hs: got aw=%0d w=%0d want 0 2", aw_c, w_c);
      else n_pass++;
      n_total++;
      if (b_l !== 1 || b_p !== 1 || resp !== 2'b00) $display("FAIL awfirst_b: got lat=%0d pulses=%0d resp=%b want 1 1 00", b_l, b_p, resp);
      else n_pass++;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(model[midx(BASE + 32'h30 + 32'(4*i))]);
         axi_read(BASE + 32'h30 + 32'(4*i), 8'd0, 0, r_l, d, resp, st, ar_a);
         e = exp_q.pop_front();
         n_total++;
         if (d !== e) $display("FAIL order_rd%0d: got %h want %h", i, d, e);
         else n_pass++;
      end
   endtask

   task automatic test_errors();
      int aw_c, w_c, b_l, b_p, r_l;
      logic [1:0] resp;
      logic [31:0] d, e;
      bit st;
      logic ar_a;
      logic [31:0] err_addr [4];
      logic [7:0]  err_len  [4];
      logic [1:0]  err_resp [4];
      err_addr = '{32'h8000_1000, 32'h7FFF_FFFC, 32'h8000_0010, 32'h8000_1000};
      err_len  = '{8'd0, 8'd0, 8'd2, 8'd1};
      err_resp = '{2'b11, 2'b11, 2'b10, 2'b11};
      for (int i = 0; i < 4; i++) begin
         axi_read(err_addr[i], err_len[i], 0, r_l, d, resp, st, ar_a);
         n_total++;
         if (resp !== err_resp[i] || d !== 32'h0 || r_l !== 1)
            $display("FAIL rd_err%0d: got resp=%b data=%h lat=%0d want %b 0 1", i, resp, d, r_l, err_resp[i]);
         else n_pass++;
      end
      axi_write(BASE + 32'h10, 8'd3, 32'h1234_5678, 4'hF, 0, aw_c, w_c, b_l, resp, b_p);
      n_total++;
      if (resp !== 2'b10 || b_p !== 1) $display("FAIL wr_slverr: got %b pulses=%0d want 10 1", resp, b_p);
      else n_pass++;
      axi_write(BASE + 32'h4, 8'd0, 32'h4444_4444, 4'hF, 0, aw_c, w_c, b_l, resp, b_p);
      model_write(BASE + 32'h4, 32'h4444_4444, 4'hF);
      axi_write(32'h8000_1004, 8'd0, 32'hFFFF_FFFF, 4'hF, 1, aw_c, w_c, b_l, resp, b_p);
      n_total++;
      if (resp !== 2'b11) $display("FAIL wr_decerr: got %b want 11", resp);
      else n_pass++;
      axi_write(BASE + 32'hFFC, 8'd0, 32'h5EED_0FFC, 4'hF, 0, aw_c, w_c, b_l, resp, b_p);
      model_write(BASE + 32'hFFC, 32'h5EED_0FFC, 4'hF);
      n_total++;
      if (resp !== 2'b00) $display("FAIL wr_lastword: got %b want 00", resp);
      else n_pass++;
      err_addr = '{BASE + 32'h10, BASE + 32'h4, BASE + 32'hFFC, BASE + 32'h10};
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(model[midx(err_addr[i])]);
         axi_read(err_addr[i], 8'd0, 0, r_l, d, resp, st, ar_a);
         e = exp_q.pop_front();
         n_total++;
         if (d !== e || resp !== 2'b00) $display("FAIL err_unchanged%0d: got %h/%b want %h/00", i, d, resp, e);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int r_l;
      logic [1:0] resp;
      logic [31:0] d, e;
      bit st;
      logic ar_a;
      exp_q.push_back(model[midx(BASE + 32'h10)]);
      axi_read(BASE + 32'h10, 8'd0, 5, r_l, d, resp, st, ar_a);
      e = exp_q.pop_front();
      n_total++;
      if (st !== 1'b1) $display("FAIL bp_stable: got %0d want 1", st);
      else n_pass++;
      n_total++;
      if (d !== e) $display("FAIL bp_data: got %h want %h", d, e);
      else n_pass++;
      n_total++;
      if (ar_a !== 1'b1) $display("FAIL bp_arready_after: got %b want 1", ar_a);
      else n_pass++;
   endtask

   task automatic test_collision();
      logic [2:0] c0;
      logic [1:0] c1;
      logic [1:0] c2;
      logic [31:0] d, e;
      araddr = BASE + 32'h40; arlen = 8'd0; arvalid = 1'b1;
      awaddr = BASE + 32'h40; awlen = 8'd0; awvalid = 1'b1;
      wdata = 32'h5A5A_5A5A; wstrb = 4'hF; wvalid = 1'b1;
      bready = 1'b1; rready = 1'b1;
      model_write(BASE + 32'h40, 32'h5A5A_5A5A, 4'hF);
      exp_q.push_back(model[midx(BASE + 32'h40)]);
      @(negedge clk);
      c0 = {arready, awready, wready};
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      c1 = {bvalid, arready};
      tick();
      @(negedge clk);
      c2 = {arready, rvalid};
      tick();
      arvalid = 1'b0;
      @(negedge clk);
      d = rvalid ? rdata : 32'hxxxx_xxxx;
      tick();
      bready = 1'b0; rready = 1'b0;
      e = exp_q.pop_front();
      n_total++;
      if (c0 !== 3'b011) $display("FAIL coll_readies: got %b want 011", c0);
      else n_pass++;
      n_total++;
      if (c1 !== 2'b10) $display("FAIL coll_bphase: got %b want 10", c1);
      else n_pass++;
      n_total++;
      if (c2 !== 2'b10) $display("FAIL coll_ar_after_b: got %b want 10", c2);
      else n_pass++;
      n_total++;
      if (d !== e) $display("FAIL coll_rdata: got %h want %h", d, e);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int aw_c, w_c, b_l, b_p, r_l, bseen;
      logic [1:0] resp;
      logic [31:0] d, e;
      bit st;
      logic ar_a;
      logic pre;
      axi_write(BASE + 32'h50, 8'd0, 32'h600D_F00D, 4'hF, 0, aw_c, w_c, b_l, resp, b_p);
      model_write(BASE + 32'h50, 32'h600D_F00D, 4'hF);
      awaddr = BASE + 32'h50; awlen = 8'd0; awvalid = 1'b1; bready = 1'b1;
      @(negedge clk);
      pre = awready;
      tick();
      awvalid = 1'b0;
      wdata = 32'hBAD0_BAD0; wstrb = 4'hF; wvalid = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0; wvalid = 1'b0;
      bseen = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bvalid) bseen++;
         tick();
      end
      bready = 1'b0;
      n_total++;
      if (pre !== 1'b1 || bseen !== 0) $display("FAIL rstmid_no_b: got awready=%b bpulses=%0d want 1 0", pre, bseen);
      else n_pass++;
      exp_q.push_back(model[midx(BASE + 32'h50)]);
      axi_read(BASE + 32'h50, 8'd0, 0, r_l, d, resp, st, ar_a);
      e = exp_q.pop_front();
      n_total++;
      if (d !== e) $display("FAIL rstmid_old_data: got %h want %h", d, e);
      else n_pass++;
      // bvalid held by bready=0, then dropped by reset
      awaddr = BASE + 32'h54; wdata = 32'h1357_9BDF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      model_write(BASE + 32'h54, 32'h1357_9BDF, 4'hF);
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      tick();
      @(negedge clk);
      pre = bvalid;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_total++;
      if (pre !== 1'b1 || bvalid !== 1'b0) $display("FAIL rst_drops_b: got before=%b after=%b want 1 0", pre, bvalid);
      else n_pass++;
      tick();
      // rvalid held by rready=0, then dropped by reset
      exp_q.push_back(model[midx(BASE + 32'h54)]);
      araddr = BASE + 32'h54; arlen = 8'd0; arvalid = 1'b1; rready = 1'b0;
      tick();
      arvalid = 1'b0;
      tick();
      @(negedge clk);
      pre = rvalid;
      d = rdata;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      e = exp_q.pop_front();
      @(negedge clk);
      n_total++;
      if (pre !== 1'b1 || d !== e || rvalid !== 1'b0)
         $display("FAIL rst_drops_r: got before=%b data=%h after=%b want 1 %h 0", pre, d, rvalid, e);
      else n_pass++;
      tick();
   endtask

   task automatic test_back_to_back();
      int aw_c, w_c, b_l, b_p, r_l, lead;
      logic [1:0] resp;
      logic [31:0] a, d, e, data;
      logic [3:0] s;
      bit st;
      logic ar_a;
      for (int i = 0; i < 8; i++) begin
         a = BASE + 32'h100 + 32'(4*i);
         data = $urandom;
         axi_write(a, 8'd0, data, 4'hF, 0, aw_c, w_c, b_l, resp, b_p);
         model_write(a, data, 4'hF);
      end
      for (int n = 0; n < 30; n++) begin
         a = BASE + 32'h100 + 32'(4 * $urandom_range(0, 7));
         if ($urandom_range(0, 1) == 0) begin
            data = $urandom;
            s = 4'($urandom_range(0, 15));
            lead = int'($urandom_range(0, 4)) - 2;
            axi_write(a, 8'd0, data, s, lead, aw_c, w_c, b_l, resp, b_p);
            model_write(a, data, s);
            n_total++;
            if (resp !== 2'b00 || b_l !== 1 || b_p !== 1)
               $display("FAIL b2b_wr%0d: got resp=%b lat=%0d pulses=%0d want 00 1 1", n, resp, b_l, b_p);
            else n_pass++;
         end else begin
            exp_q.push_back(model[midx(a)]);
            axi_read(a, 8'd0, int'($urandom_range(0, 2)), r_l, d, resp, st, ar_a);
            e = exp_q.pop_front();
            n_total++;
            if (d !== e || resp !== 2'b00 || r_l !== 1 || st !== 1'b1)
               $display("FAIL b2b_rd%0d: got %h/%b lat=%0d st=%0d want %h/00 1 1", n, d, resp, r_l, st, e);
            else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_strobes();
      test_channel_order();
      test_errors();
      test_backpressure();
      test_collision();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
      $fatal(1);
   end

endmodule
